// File: rtl/max7219_display_ctrl.sv
// max7219_display_ctrl: drives the MAX7219 serial port with an init sequence and 9-word display frames
//   i_clk, i_reset_n      system clock, synchronous active-low reset
//   i_update              frame request (pulse or level)
//   i_digits[64]          digit n = i_digits[8n+7:8n], segment byte {dp,a..g}
//   i_intensity[4]        intensity nibble, sampled when the intensity word is loaded
//   o_busy, o_done        word engine active; one-cycle pulse after a frame's last word latches
//   o_serial_load/dout/clk  MAX7219 LOAD, DIN (MSB first), CLK
module max7219_display_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_update,
    input  logic [63:0] i_digits,
    input  logic [3:0]  i_intensity,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_serial_load,
    output logic        o_serial_dout,
    output logic        o_serial_clk
);
    localparam int DW = $clog2(CLK_DIV) + 1;
    typedef enum logic [2:0] {S_IDLE, S_LD, S_LO, S_HI, S_LATCH} state_t;
    state_t state, state_nx;
    logic [DW-1:0] div;
    logic [3:0] bit_cnt, idx;
    logic frame, pending, done_r;
    logic [15:0] sh, word;
    logic [63:0] fbuf;
    logic [2:0] dsel;
    logic div_end, last_word, word_end, start;
    always_comb begin
        div_end = div == DW'(CLK_DIV - 1);
        last_word = frame ? idx == 4'd8 : idx == 4'd4;
        word_end = state == S_LATCH && div_end;
        // a request seen in the final LATCH cycle chains straight into the next frame
        start = (state == S_IDLE && i_update) || (word_end && last_word && (pending || i_update));
        dsel = 3'(idx - 4'd1);
        word = frame ? (idx == 4'd0 ? {12'h0A0, i_intensity} : {4'h0, idx, fbuf[{dsel, 3'b000} +: 8]})
             : idx == 4'd0 ? 16'h0C01
             : idx == 4'd1 ? 16'h0900
             : idx == 4'd2 ? 16'h0B07
             : idx == 4'd3 ? {12'h0A0, i_intensity}
             : 16'h0F00;
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = i_update ? S_LD : S_IDLE;
            S_LD:    state_nx = S_LO;
            S_LO:    state_nx = div_end ? S_HI : S_LO;
            S_HI:    state_nx = !div_end ? S_HI : bit_cnt == 4'd15 ? S_LATCH : S_LO;
            S_LATCH: state_nx = !div_end ? S_LATCH : (!last_word || start) ? S_LD : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= S_LD;
            div <= '0;
            bit_cnt <= '0;
            idx <= '0;
            frame <= 1'b0;
            pending <= 1'b0;
            done_r <= 1'b0;
            sh <= '0;
        end else begin
            state <= state_nx;
            div <= (state == S_LO || state == S_HI || state == S_LATCH) && !div_end ? div + DW'(1) : '0;
            pending <= !start && (pending || (i_update && state != S_IDLE));
            done_r <= word_end && last_word && frame;
            if (state == S_LD)
                sh <= word;
            if (state == S_HI && div_end) begin
                sh <= {sh[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (start) begin
                frame <= 1'b1;
                idx <= '0;
                fbuf <= i_digits;
            end else if (word_end && idx != 4'hF) begin
                idx <= idx + 4'd1;
            end
        end
    end
    assign o_busy = state != S_IDLE;
    assign o_done = done_r;
    assign o_serial_load = state == S_IDLE || state == S_LD || state == S_LATCH;
    assign o_serial_clk = state == S_HI;
    assign o_serial_dout = (state == S_LO || state == S_HI) && sh[15];
endmodule

// File: tb/tb_max7219_display_ctrl.sv
// tb_max7219_display_ctrl: serial-decoding bench for max7219_display_ctrl at CLK_DIV=1 and CLK_DIV=3
module tb_max7219_display_ctrl;
    typedef struct {
        logic [31:0] bcd;
        logic [3:0]  inten;
        int          lat;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, update = 1'b0;
    logic [63:0] digits = '0;
    logic [3:0] inten = 4'd8;
    logic busy[2], done[2], ld[2], dq[2], sk[2];
    int checks = 0, failures = 0, cyc = 0;
    int nb[2], hr[2], lr[2], lowc[2], donec[2];
    logic pld[2], psk[2], pdq[2];
    logic [15:0] sh[2];
    logic [15:0] q0[$], q1[$], expq[$];
    int rq1[$];
    int done_cyc = 0, last_rise = 0;
    logic [7:0] seg_tab[10] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        max7219_display_ctrl #(.CLK_DIV(g == 0 ? 1 : 3)) dut (
            .i_clk(clk), .i_reset_n(rst_n), .i_update(update), .i_digits(digits),
            .i_intensity(inten), .o_busy(busy[g]), .o_done(done[g]), .o_serial_load(ld[g]),
            .o_serial_dout(dq[g]), .o_serial_clk(sk[g])
        );
    end
    function automatic int cdv(input int g);
        return g == 0 ? 1 : 3;
    endfunction
    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask
    function automatic logic [63:0] enc(input logic [31:0] bcd);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = seg_tab[bcd[4*k +: 4]];
        return r;
    endfunction
    function automatic int seg2dig(input logic [7:0] s);
        for (int k = 0; k < 10; k++) if (seg_tab[k] == s) return k;
        return 15;
    endfunction
    function automatic logic [31:0] rbcd();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction
    task automatic add_init(input logic [3:0] in);
        expq.push_back(16'h0C01);
        expq.push_back(16'h0900);
        expq.push_back(16'h0B07);
        expq.push_back({12'h0A0, in});
        expq.push_back(16'h0F00);
    endtask
    task automatic add_frame(input logic [31:0] bcd, input logic [3:0] in);
        expq.push_back({12'h0A0, in});
        for (int k = 0; k < 8; k++) expq.push_back({8'(k + 1), seg_tab[bcd[4*k +: 4]]});
    endtask
    task automatic cmp_words(input string nm, input bit second);
        logic [15:0] q[$];
        if (second) q = q1; else q = q0;
        chk({nm, "_count"}, q.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (i < q.size()) chk($sformatf("%s_w%0d", nm, i), int'(q[i]), int'(expq[i]));
    endtask
    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        while (busy[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle_timeout%0d", g), int'(busy[g]), 0);
    endtask
    task automatic pulse();
        @(negedge clk);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask
    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                nb[g] = 0; hr[g] = 0; lr[g] = 0; lowc[g] = 0; sh[g] = '0;
                pld[g] = 1'b1; psk[g] = 1'b0; pdq[g] = 1'b0;
            end else begin
                if (!ld[g] && pld[g]) begin
                    nb[g] = 0;
                    lowc[g] = 0;
                end
                if (!ld[g]) lowc[g]++;
                if (sk[g] && !psk[g]) begin
                    chk($sformatf("dout_stable%0d", g), int'(dq[g]), int'(pdq[g]));
                    chk($sformatf("sclk_low%0d", g), lr[g], cdv(g));
                    sh[g] = {sh[g][14:0], dq[g]};
                    nb[g]++;
                end
                if (sk[g]) hr[g] = psk[g] ? hr[g] + 1 : 1;
                else if (psk[g]) chk($sformatf("sclk_high%0d", g), hr[g], cdv(g));
                lr[g] = (!ld[g] && !sk[g]) ? lr[g] + 1 : 0;
                if (ld[g] && !pld[g]) begin
                    chk($sformatf("load_low%0d", g), lowc[g], 32 * cdv(g));
                    if (nb[g] == 16) begin
                        if (g == 0) q0.push_back(sh[g]);
                        else begin
                            q1.push_back(sh[g]);
                            rq1.push_back(cyc);
                        end
                    end
                    if (g == 0) last_rise = cyc;
                end
                if (done[g]) begin
                    donec[g]++;
                    if (g == 0) done_cyc = cyc;
                end
                pld[g] = ld[g]; psk[g] = sk[g]; pdq[g] = dq[g];
            end
        end
    end
    initial begin
        vec_t vt[4];
        logic [31:0] cur, nxt;
        int u, d0, n, l5, nfr;
        vt[0] = '{32'h00654321, 4'd8, 306};
        vt[1] = '{32'h98765432, 4'd15, 306};
        vt[2] = '{32'h00000000, 4'd0, 306};
        vt[3] = '{32'h88888888, 4'd7, 306};
        donec = '{0, 0};
        repeat (3) @(negedge clk);
        chk("rst_load", int'(ld[0]), 1);
        chk("rst_dout", int'(dq[0]), 0);
        chk("rst_sclk", int'(sk[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_busy", int'(busy[0]), 1);
        rst_n = 1'b1;
        wait_idle(0, 400);
        wait_idle(1, 1000);
        add_init(4'd8);
        cmp_words("init", 1'b0);
        cmp_words("init3", 1'b1);
        for (int i = 0; i + 1 < rq1.size(); i++) chk($sformatf("word_period3_%0d", i), rq1[i+1] - rq1[i], 100);
        chk("init_no_done", donec[0] + donec[1], 0);
        chk("init_idle", int'(busy[0]), 0);
        for (int v = 0; v < 4; v++) begin
            digits = enc(vt[v].bcd);
            inten = vt[v].inten;
            q0.delete();
            expq.delete();
            add_frame(vt[v].bcd, vt[v].inten);
            d0 = donec[0];
            @(negedge clk);
            u = cyc;
            update = 1'b1;
            @(negedge clk);
            update = 1'b0;
            wait_idle(0, 400);
            cmp_words($sformatf("vec%0d", v), 1'b0);
            for (int k = 0; k < 8; k++)
                if (q0.size() > k + 1) chk($sformatf("vec%0d_dig%0d", v, k), seg2dig(q0[k+1][7:0]), int'(vt[v].bcd[4*k +: 4]));
            chk($sformatf("vec%0d_done_lat", v), done_cyc - (u + 1), vt[v].lat);
            chk($sformatf("vec%0d_done_cnt", v), donec[0] - d0, 1);
        end
        cur = 32'h13572468;
        nxt = 32'h24680135;
        q0.delete();
        expq.delete();
        digits = enc(cur);
        d0 = donec[0];
        pulse();
        repeat (40) @(negedge clk);
        digits = enc(nxt);
        pulse();
        repeat (20) @(negedge clk);
        pulse();
        repeat (100) @(negedge clk);
        pulse();
        add_frame(cur, inten);
        add_frame(nxt, inten);
        wait_idle(0, 1000);
        cmp_words("coalesce", 1'b0);
        chk("coalesce_done_cnt", donec[0] - d0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q0.delete();
        expq.delete();
        d0 = donec[0];
        update = 1'b1;
        rst_n = 1'b1;
        n = 0;
        while (q0.size() < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("held_init_words", q0.size(), 5);
        l5 = last_rise;
        update = 1'b0;
        wait_idle(0, 800);
        add_init(inten);
        add_frame(nxt, inten);
        cmp_words("held", 1'b0);
        chk("held_no_gap", done_cyc - l5, 307);
        chk("held_done_cnt", donec[0] - d0, 1);
        q0.delete();
        pulse();
        n = 0;
        while (!(q0.size() == 3 && nb[0] == 7) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_bit7", nb[0], 7);
        chk("abort_mid_load", int'(ld[0]), 0);
        d0 = donec[0];
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_load", int'(ld[0]), 1);
        chk("abort_sclk", int'(sk[0]), 0);
        chk("abort_dout", int'(dq[0]), 0);
        chk("abort_busy", int'(busy[0]), 1);
        chk("abort_words", q0.size(), 3);
        q0.delete();
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(0, 400);
        add_init(inten);
        cmp_words("replay", 1'b0);
        chk("replay_no_done", donec[0] - d0, 0);
        for (int it = 0; it < 8; it++) begin
            wait_idle(0, 1000);
            q0.delete();
            expq.delete();
            d0 = donec[0];
            cur = rbcd();
            inten = 4'($urandom_range(0, 15));
            digits = enc(cur);
            pulse();
            add_frame(cur, inten);
            nfr = 1;
            repeat ($urandom_range(5, 200)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                cur = rbcd();
                digits = enc(cur);
                repeat ($urandom_range(1, 3)) begin
                    pulse();
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                end
                add_frame(cur, inten);
                nfr = 2;
            end
            wait_idle(0, 1000);
            cmp_words($sformatf("rand%0d", it), 1'b0);
            chk($sformatf("rand%0d_done_cnt", it), donec[0] - d0, nfr);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
